// File: rtl/id1000500a_conv_core.sv
// Sequential 1-D convolution core: Z[n] = sum_k X[k]*Y[n-k] over two synchronous-read RAMs,
// one multiply-accumulate per READ/MAC pair, one Z write per output index.
module id1000500a_conv_core #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     config_in,
  output logic [ADDR_WIDTH-1:0]     memX_addr,
  input  logic [DATA_WIDTH-1:0]     dataX,
  output logic [ADDR_WIDTH-1:0]     memY_addr,
  input  logic [DATA_WIDTH-1:0]     dataY,
  output logic [2*DATA_WIDTH-1:0]   dataZ,
  output logic [ADDR_WIDTH:0]       memZ_addr,
  output logic                      writeZ,
  output logic                      busy_out,
  output logic                      done_out,
  output logic [2:0]                dbg_state_o
);

  localparam int AW = ADDR_WIDTH;
  localparam int NW = ADDR_WIDTH + 1;
  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_READ  = 3'd2,
    S_MAC   = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   size_x_q, size_x_d;
  logic [AW-1:0]   size_y_q, size_y_d;
  logic [NW-1:0]   size_z_q, size_z_d;
  logic [NW-1:0]   n_q, n_d;
  logic [AW-1:0]   k_q, k_d;
  logic [AW-1:0]   kmax_q, kmax_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [AW-1:0]   addr_x_q, addr_x_d;
  logic [AW-1:0]   addr_y_q, addr_y_d;

  logic [AW-1:0]   cfg_x, cfg_y;
  logic [NW-1:0]   n_plus1;
  logic [NW-1:0]   kmin_wide;
  logic [AW-1:0]   kmin_c, kmax_c;
  logic [AW-1:0]   k_next;
  logic [NW-1:0]   y_wide;
  logic [PW-1:0]   prod_c;
  logic            unused_cfg_bits;

  assign cfg_x = config_in[AW-1:0];
  assign cfg_y = config_in[2*AW-1:AW];
  assign unused_cfg_bits = ^config_in[DATA_WIDTH-1:2*AW];

  // k range for the current n: kmin = max(0, n-sizeY+1), kmax = min(n, sizeX-1)
  assign n_plus1   = n_q + NW'(1);
  assign kmin_wide = (n_plus1 > {1'b0, size_y_q}) ? (n_plus1 - {1'b0, size_y_q}) : '0;
  assign kmin_c    = kmin_wide[AW-1:0];
  assign kmax_c    = (n_q < {1'b0, size_x_q}) ? n_q[AW-1:0] : (size_x_q - AW'(1));

  // Addresses for the next read are registered one state early so they sit on the
  // RAM ports throughout READ; the RAM data then arrives during MAC.
  assign k_next = (state_q == S_INIT) ? kmin_c : (k_q + AW'(1));
  assign y_wide = n_q - {1'b0, k_next};
  assign prod_c = {{DATA_WIDTH{1'b0}}, dataX} * {{DATA_WIDTH{1'b0}}, dataY};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      size_x_q <= '0;
      size_y_q <= '0;
      size_z_q <= '0;
      n_q      <= '0;
      k_q      <= '0;
      kmax_q   <= '0;
      acc_q    <= '0;
      addr_x_q <= '0;
      addr_y_q <= '0;
    end else begin
      state_q  <= state_d;
      size_x_q <= size_x_d;
      size_y_q <= size_y_d;
      size_z_q <= size_z_d;
      n_q      <= n_d;
      k_q      <= k_d;
      kmax_q   <= kmax_d;
      acc_q    <= acc_d;
      addr_x_q <= addr_x_d;
      addr_y_q <= addr_y_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    size_x_d = size_x_q;
    size_y_d = size_y_q;
    size_z_d = size_z_q;
    n_d      = n_q;
    k_d      = k_q;
    kmax_d   = kmax_q;
    acc_d    = acc_q;
    addr_x_d = addr_x_q;
    addr_y_d = addr_y_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          size_x_d = cfg_x;
          size_y_d = cfg_y;
          size_z_d = {1'b0, cfg_x} + {1'b0, cfg_y} - NW'(1);
          n_d      = '0;
          acc_d    = '0;
          state_d  = ((cfg_x == '0) || (cfg_y == '0)) ? S_DONE : S_INIT;
        end
      end
      S_INIT: begin
        acc_d    = '0;
        k_d      = kmin_c;
        kmax_d   = kmax_c;
        addr_x_d = k_next;
        addr_y_d = y_wide[AW-1:0];
        state_d  = S_READ;
      end
      S_READ: begin
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + prod_c;
        if (k_q < kmax_q) begin
          k_d      = k_next;
          addr_x_d = k_next;
          addr_y_d = y_wide[AW-1:0];
          state_d  = S_READ;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (n_q < (size_z_q - NW'(1))) begin
          n_d     = n_q + NW'(1);
          state_d = S_INIT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign memX_addr   = addr_x_q;
  assign memY_addr   = addr_y_q;
  assign dataZ       = acc_q;
  assign memZ_addr   = n_q;
  assign writeZ      = (state_q == S_WRITE);
  assign busy_out    = (state_q == S_INIT) || (state_q == S_READ) ||
                       (state_q == S_MAC)  || (state_q == S_WRITE);
  assign done_out    = (state_q == S_DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_id1000500a_conv_core.sv
// Directed bench for id1000500a_conv_core: synchronous-read X/Y RAM models, a write
// monitor feeding queues, and hand-computed expected Z sequences.
module tb_id1000500a_conv_core;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] config_in;
  logic [4:0]  memX_addr;
  logic [31:0] dataX;
  logic [4:0]  memY_addr;
  logic [31:0] dataY;
  logic [63:0] dataZ;
  logic [5:0]  memZ_addr;
  logic        writeZ;
  logic        busy_out;
  logic        done_out;
  logic [2:0]  dbg_state;

  logic [31:0] x_mem [0:31];
  logic [31:0] y_mem [0:31];

  logic [63:0] exp_q[$];
  logic [63:0] wr_data_q[$];
  logic [5:0]  wr_addr_q[$];
  int          done_cnt;
  logic        busy_at_done;
  int          cyc;
  int          last_wr_cyc;
  int          done_cyc;
  int          checks;
  int          errors;

  id1000500a_conv_core #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .config_in   (config_in),
    .memX_addr   (memX_addr),
    .dataX       (dataX),
    .memY_addr   (memY_addr),
    .dataY       (dataY),
    .dataZ       (dataZ),
    .memZ_addr   (memZ_addr),
    .writeZ      (writeZ),
    .busy_out    (busy_out),
    .done_out    (done_out),
    .dbg_state_o (dbg_state)
  );

  // clock / RAM models / monitor
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    dataX <= x_mem[memX_addr];
    dataY <= y_mem[memY_addr];
    cyc   <= cyc + 1;
  end

  always @(negedge clk) begin
    if (writeZ === 1'b1) begin
      wr_addr_q.push_back(memZ_addr);
      wr_data_q.push_back(dataZ);
      last_wr_cyc = cyc;
    end
    if (done_out === 1'b1) begin
      done_cnt++;
      busy_at_done = busy_out;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_job();
    wr_addr_q.delete();
    wr_data_q.delete();
    exp_q.delete();
    done_cnt    = 0;
    last_wr_cyc = -1;
    done_cyc    = -1;
  endtask

  task automatic start_job(input logic [4:0] sx, input logic [4:0] sy);
    @(posedge clk); #1;
    config_in = {22'h0, sy, sx};
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c;
    c = 0;
    while (done_cnt == 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    repeat (2) @(posedge clk);
    #1;
    check({tag, " done_within_budget"}, 64'(done_cnt != 0), 64'd1);
    check({tag, " busy_low_after"}, 64'(busy_out), 64'd0);
  endtask

  task automatic compare_job(input string tag);
    check({tag, " write_count"}, 64'(wr_data_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
      check($sformatf("%s addr[%0d]", tag, i), 64'(wr_addr_q[i]), 64'(i));
      check($sformatf("%s Z[%0d]", tag, i), wr_data_q[i], exp_q[i]);
    end
    check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, " busy_at_done"}, 64'(busy_at_done), 64'd0);
    if (exp_q.size() != 0)
      check({tag, " done_after_last_write"}, 64'(done_cyc > last_wr_cyc), 64'd1);
  endtask

  task automatic load_ref_mems();
    for (int i = 0; i < 32; i++) begin
      x_mem[i] = (i < 5)  ? 32'(i + 1) : 32'hDEAD_0000;
      y_mem[i] = (i < 10) ? 32'(i + 1) : 32'hBEEF_0000;
    end
  endtask

  task automatic push_ref_expected();
    logic [63:0] ref_z [0:13];
    ref_z = '{64'd1, 64'd4, 64'd10, 64'd20, 64'd35, 64'd50, 64'd65,
              64'd80, 64'd95, 64'd110, 64'd114, 64'd106, 64'd85, 64'd50};
    for (int i = 0; i < 14; i++) exp_q.push_back(ref_z[i]);
  endtask

  initial begin
    int c;
    int saved;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst       = 1'b1;
    start     = 1'b0;
    config_in = '0;
    for (int i = 0; i < 32; i++) begin
      x_mem[i] = '0;
      y_mem[i] = '0;
    end
    clear_job();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst writeZ", 64'(writeZ), 64'd0);
    check("rst busy", 64'(busy_out), 64'd0);
    check("rst done", 64'(done_out), 64'd0);
    check("rst dataZ", dataZ, 64'd0);
    check("rst memZ_addr", 64'(memZ_addr), 64'd0);
    check("rst memX_addr", 64'(memX_addr), 64'd0);
    check("rst memY_addr", 64'(memY_addr), 64'd0);
    check("rst state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 5 x 10 reference job
    load_ref_mems();
    clear_job();
    push_ref_expected();
    start_job(5'd5, 5'd10);
    check("ref busy_after_start", 64'(busy_out), 64'd1);
    wait_done("ref", 1000);
    compare_job("ref");

    // 1 x 1 small product
    x_mem[0] = 32'd3;
    y_mem[0] = 32'd7;
    clear_job();
    exp_q.push_back(64'd21);
    start_job(5'd1, 5'd1);
    wait_done("one", 200);
    compare_job("one");

    // 1 x 1 full-width product
    x_mem[0] = 32'hFFFF_FFFF;
    y_mem[0] = 32'hFFFF_FFFF;
    clear_job();
    exp_q.push_back(64'hFFFF_FFFE_0000_0001);
    start_job(5'd1, 5'd1);
    wait_done("max", 200);
    compare_job("max");

    // empty job: sizeX = 0
    clear_job();
    start_job(5'd0, 5'd4);
    wait_done("empty", 50);
    compare_job("empty");

    // start re-pulsed and config changed mid-job
    load_ref_mems();
    clear_job();
    push_ref_expected();
    start_job(5'd5, 5'd10);
    repeat (20) @(posedge clk);
    #1;
    config_in = {22'h0, 5'd3, 5'd2};
    start     = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    start     = 1'b0;
    wait_done("disturb", 1000);
    compare_job("disturb");

    // reset while writeZ is high, then a fresh run
    clear_job();
    start_job(5'd5, 5'd10);
    c = 0;
    while (!(writeZ === 1'b1 && wr_data_q.size() >= 3) && c < 1000) begin
      @(posedge clk); #1;
      c++;
    end
    check("abort reached_write", 64'(writeZ), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("abort writeZ", 64'(writeZ), 64'd0);
    check("abort busy", 64'(busy_out), 64'd0);
    check("abort done", 64'(done_out), 64'd0);
    check("abort state", 64'(dbg_state), 64'd0);
    saved = wr_data_q.size();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort no_more_writes", 64'(wr_data_q.size()), 64'(saved));
    check("abort no_done", 64'(done_cnt), 64'd0);

    clear_job();
    push_ref_expected();
    start_job(5'd5, 5'd10);
    wait_done("restart", 1000);
    compare_job("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
